// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32-M multi-cycle multiply/divide sequencer:
// funct3 opcodes, the M-extension funct7 value, FSM state encoding,
// special-case divide constants and small opcode-decode helpers.
package muldiv_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned CNT_W    = 5;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [31:0] DIV0_Q     = 32'hFFFF_FFFF;
    localparam logic [31:0] SIGNED_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIXUP,
        ST_DONE
    } state_e;

    // Multiplies occupy the lower half of the funct3 space.
    function automatic logic f3_is_mul(input logic [2:0] f3);
        return ~f3[2];
    endfunction

    // DIV and REM are the signed divide flavours (funct3[0] clear).
    function automatic logic f3_is_signed_div(input logic [2:0] f3);
        return f3[2] & ~f3[0];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and muldiv_seq.
// master: requester (drives req_valid, a, b, funct3, flush, resp_ready).
// slave : muldiv_seq (drives req_ready, resp_valid, res, busy).
interface muldiv_if #(
    parameter int unsigned XLEN = 32
);
    import muldiv_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      funct3;
    logic            flush;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] res;
    logic            busy;

    modport master (
        output req_valid, a, b, funct3, flush, resp_ready,
        input  req_ready, resp_valid, res, busy
    );

    modport slave (
        input  req_valid, a, b, funct3, flush, resp_ready,
        output req_ready, resp_valid, res, busy
    );

endinterface

// File: rtl/muldiv_seq_div_step.sv
// One combinational restoring-division step.
// rem_i     : partial remainder (always < dvs_i)
// dvd_bit_i : next dividend bit shifted in
// dvs_i     : divisor magnitude
// rem_nxt_c : remainder after the step
// q_bit_c   : quotient bit produced by the step
module div_step
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            dvd_bit_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_nxt_c,
    output logic            q_bit_c
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Since rem_i < dvs_i, a non-negative trial difference always fits in
    // XLEN bits, so the top bit of diff is a clean borrow flag.
    always_comb begin
        shifted   = {rem_i, dvd_bit_i};
        diff      = shifted - {1'b0, dvs_i};
        q_bit_c   = ~diff[XLEN];
        rem_nxt_c = q_bit_c ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32-M sequencer: counted-wait multiply and an iterative
// 1-bit-per-cycle restoring divider, with valid/ready request/response.
// clk, rst_n : clock (rising edge), asynchronous active-low reset
// bus        : muldiv_if slave (request, flush, response, busy)
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [2:0]        f3_q, f3_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic              resp_valid_q, resp_valid_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              sdiv;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              mul_a_sgn, mul_b_sgn;
    logic [2*XLEN-1:0] ext_a, ext_b, prod;
    logic [XLEN-1:0]   step_rem;
    logic              step_q;

    assign bus.req_ready  = (state_q == ST_IDLE) && !bus.flush;
    assign bus.resp_valid = resp_valid_q;
    assign bus.res        = res_q;
    assign bus.busy       = busy_q;

    // Operand decode at accept time: magnitudes only for signed divides.
    always_comb begin
        accept = bus.req_valid && (state_q == ST_IDLE) && !bus.flush;
        sdiv   = f3_is_signed_div(bus.funct3);
        a_neg  = bus.a[XLEN-1];
        b_neg  = bus.b[XLEN-1];
        mag_a  = (sdiv && a_neg) ? -bus.a : bus.a;
        mag_b  = (sdiv && b_neg) ? -bus.b : bus.b;
    end

    // 64-bit product from latched operands; sign extension picks the flavour.
    always_comb begin
        mul_a_sgn = (f3_q == F3_MULH) || (f3_q == F3_MULHSU);
        mul_b_sgn = (f3_q == F3_MULH);
        ext_a     = {{XLEN{opa_q[XLEN-1] & mul_a_sgn}}, opa_q};
        ext_b     = {{XLEN{opb_q[XLEN-1] & mul_b_sgn}}, opb_q};
        prod      = ext_a * ext_b;
    end

    // opa_q doubles as the dividend/quotient shift register during DIV.
    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i     (rem_q),
        .dvd_bit_i (opa_q[XLEN-1]),
        .dvs_i     (opb_q),
        .rem_nxt_c (step_rem),
        .q_bit_c   (step_q)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        rem_d        = rem_q;
        res_d        = res_q;
        f3_d         = f3_q;
        negq_d       = negq_q;
        negr_d       = negr_q;
        resp_valid_d = resp_valid_q;
        busy_d       = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    f3_d   = bus.funct3;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (f3_is_mul(bus.funct3)) begin
                        opa_d   = bus.a;
                        opb_d   = bus.b;
                        cnt_d   = CNT_W'(MUL_STAGES - 1);
                        state_d = ST_MUL;
                    end else if (bus.b == '0) begin
                        res_d        = bus.funct3[1] ? bus.a : DIV0_Q;
                        resp_valid_d = 1'b1;
                        state_d      = ST_DONE;
                    end else if (sdiv && (bus.a == SIGNED_MIN) && (bus.b == '1)) begin
                        res_d        = bus.funct3[1] ? '0 : SIGNED_MIN;
                        resp_valid_d = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        opa_d   = mag_a;
                        opb_d   = mag_b;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(XLEN - 1);
                        negq_d  = sdiv && (a_neg != b_neg);
                        negr_d  = sdiv && a_neg;
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    res_d        = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    resp_valid_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV: begin
                rem_d = step_rem;
                opa_d = {opa_q[XLEN-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = ST_FIXUP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FIXUP: begin
                if (f3_q[1]) begin
                    res_d = negr_q ? -rem_q : rem_q;
                end else begin
                    res_d = negq_q ? -opa_q : opa_q;
                end
                resp_valid_d = 1'b1;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase

        // Flush wins over everything, but the last result stays visible on res.
        if (bus.flush) begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b0;
            busy_d       = 1'b0;
            cnt_d        = '0;
            res_d        = res_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            rem_q        <= '0;
            res_q        <= '0;
            f3_q         <= '0;
            negq_q       <= 1'b0;
            negr_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            rem_q        <= rem_d;
            res_q        <= res_d;
            f3_q         <= f3_d;
            negq_q       <= negq_d;
            negr_q       <= negr_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: the driver pushes reference results and
// latencies at accept; a negedge monitor pops and compares on each response.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int unsigned XL = 32;
    localparam int unsigned MS = 2;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t cur;
    logic prev_rv = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_if #(.XLEN(XL)) bus ();

    muldiv_seq #(.XLEN(XL), .MUL_STAGES(MS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: RV32-M semantics via plain 64-bit and signed integer arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        int              sa, sb_;
        longint          p;
        longint unsigned up;
        logic [31:0]     r;
        sa  = a;
        sb_ = b;
        up  = {32'b0, a} * {32'b0, b};
        r   = '0;
        case (f3)
            F3_MUL:    r = up[31:0];
            F3_MULH:   begin p = longint'(sa) * longint'(sb_);         r = p[63:32]; end
            F3_MULHSU: begin p = longint'(sa) * longint'({32'b0, b});  r = p[63:32]; end
            F3_MULHU:  r = up[63:32];
            F3_DIV: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = sa / sb_;
            end
            F3_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = sa % sb_;
            end
            default:   r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Edges from accept (counted as edge 1) until resp_valid is seen high.
    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3 < 3'd4) return MS + 1;
        if (b == 0) return 1;
        if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return XL + 2;
    endfunction

    // Monitor: compares value and latency on each new response, then stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rv = 1'b0;
        end else begin
            if (bus.resp_valid && !prev_rv) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_resp: got res %08h expected no response (cycle %0d)",
                             bus.res, cyc);
                end else begin
                    cur = sb.pop_front();
                    check("res", bus.res, cur.res);
                    check("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
                end
            end else if (bus.resp_valid) begin
                check("res_stable", bus.res, cur.res);
            end
            prev_rv = bus.resp_valid;
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        int w;
        w = 0;
        while (!bus.req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        bus.req_valid = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.funct3    = f3;
        @(posedge clk);
        #1;
        if (push) sb.push_back('{ref_res(f3, a, b), ref_lat(f3, a, b), cyc});
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.funct3    = 3'($urandom);
    endtask

    task automatic wait_resp(input int hold);
        int w;
        w = 0;
        bus.resp_ready = (hold == 0);
        while (!bus.resp_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus.resp_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_timeout: got resp_valid 0 expected 1");
        end
        repeat (hold) @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input int hold);
        issue(f3, a, b, 1'b1);
        wait_resp(hold);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] ra, rb;
        int          r;

        bus.req_valid  = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.funct3     = '0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_res", bus.res, 32'h0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 32'(bus.req_ready), 32'h1);

        // Directed divides.
        op(F3_DIVU, 32'd100, 32'd7, 0);
        op(F3_REMU, 32'd100, 32'd7, 0);
        issue(F3_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        repeat (5) begin
            check("div_busy", 32'(bus.busy), 32'h1);
            check("div_req_ready", 32'(bus.req_ready), 32'h0);
            @(negedge clk);
        end
        wait_resp(0);
        op(F3_REM,  32'hFFFF_FFF9, 32'd2, 0);
        op(F3_DIVU, 32'd5, 32'd0, 0);
        op(F3_REMU, 32'd5, 32'd0, 0);
        op(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        op(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Directed multiplies.
        op(F3_MULH,   32'h8000_0000, 32'h8000_0000, 0);
        op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        op(F3_MUL,    32'd3, 32'hFFFF_FFFF, 0);

        // Backpressure: response held for five cycles.
        op(F3_DIV,   32'd12345, 32'hFFFF_FFB3, 5);
        op(F3_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5);

        // Flush mid-divide, then a flushed request that must not be taken.
        issue(F3_DIV, 32'd1000, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_busy", 32'(bus.busy), 32'h0);
        check("flush_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("flush_req_ready", 32'(bus.req_ready), 32'h0);
        bus.req_valid = 1'b1;
        bus.a         = 32'd50;
        bus.b         = 32'd5;
        bus.funct3    = F3_DIVU;
        @(posedge clk);
        #1;
        check("flush_no_accept", 32'(bus.busy), 32'h0);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("post_flush_busy", 32'(bus.busy), 32'h0);
        op(F3_DIVU, 32'd9, 32'd3, 0);

        // Reset pulse mid-multiply.
        issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(bus.busy), 32'h0);
        check("rst_mid_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_mid_res", bus.res, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Randomised operations with random backpressure.
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom);
            ra = $urandom;
            r  = $urandom_range(0, 15);
            if (r == 0) begin
                rb = 32'h0;
            end else if (r < 4) begin
                rb = 32'($urandom_range(1, 20));
                if ($urandom_range(0, 1) == 1) rb = -rb;
            end else if (r == 4) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end else begin
                rb = $urandom;
            end
            op(f3, ra, rb, $urandom_range(0, 3));
        end

        repeat (5) @(negedge clk);
        check("pending_expectations", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
